// File: rtl/jram_sync_if.sv
// Bus-side signal bundle for jram_sync: MAR/data strobes in, read data and status out.
interface jram_sync_if #(
  parameter int DW = 8,
  parameter int AW = 8
) ();
  logic [AW-1:0] bas;
  logic          wsa;
  logic [DW-1:0] bis;
  logic          ws;
  logic          we;
  logic [DW-1:0] bos;
  logic          valid;
  logic          busy;
  logic [AW-1:0] mar;

  modport master (
    output bas, wsa, bis, ws, we,
    input  bos, valid, busy, mar
  );

  modport slave (
    input  bas, wsa, bis, ws, we,
    output bos, valid, busy, mar
  );
endinterface

// File: rtl/jram_sync.sv
// MAR-addressed synchronous RAM with registered read (RD_LAT 1 or 2) and post-reset clear sweep.
// Optional macro JRAM_AUTOINC_EN: ws/we without wsa post-increment the MAR.
module jram_sync #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  jram_sync_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("jram_sync: RD_LAT must be 1 or 2");
    end
  endgenerate

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] mar_q, mar_nxt;
  logic [AW-1:0] clr_ptr;
  logic          busy_q;
  logic          wr_en, rd_en;

  logic [DW-1:0] mem [DEPTH];

  logic          out_vld;
  logic [DW-1:0] out_data;
  logic          valid_p1;
  logic [DW-1:0] bos_p1;

  always_comb begin
    state_nxt = state;
    mar_nxt   = mar_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      CLEAR: begin
        if (clr_ptr == {AW{1'b1}}) state_nxt = IDLE;
      end
      IDLE: begin
        wr_en = bus.ws;
        rd_en = bus.we;
        if (bus.wsa) begin
          mar_nxt = bus.bas;
        end
`ifdef JRAM_AUTOINC_EN
        else if (bus.ws || bus.we) begin
          mar_nxt = mar_q + AW'(1);
        end
`endif
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      mar_q    <= '0;
      busy_q   <= 1'b1;
      valid_p1 <= 1'b0;
      bos_p1   <= '0;
    end else begin
      state    <= state_nxt;
      busy_q   <= (state_nxt == CLEAR);
      mar_q    <= mar_nxt;
      if (state == CLEAR) clr_ptr <= clr_ptr + AW'(1);
      valid_p1 <= out_vld;
      bos_p1   <= out_vld ? out_data : '0;
    end
  end

  // Array writes are suppressed on a reset edge so a pending ws is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_en)     mem[mar_q]   <= bis_hold();
    end
  end

  function automatic logic [DW-1:0] bis_hold();
    return bus.bis;
  endfunction

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          vld_p0;
      logic [DW-1:0] rd_p0;

      // Stage p0: array read register, nonblocking so a same-edge write is not seen.
      always_ff @(posedge clk) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= rd_en;
      end

      always_ff @(posedge clk) begin
        rd_p0 <= mem[mar_q];
      end

      assign out_vld  = vld_p0;
      assign out_data = rd_p0;
    end else begin : g_lat1
      assign out_vld  = rd_en;
      assign out_data = mem[mar_q];
    end
  endgenerate

  // Stage p1: output register, zero whenever no read is presented.
  assign bus.bos   = bos_p1;
  assign bus.valid = valid_p1;
  assign bus.busy  = busy_q;
  assign bus.mar   = mar_q;
endmodule

// File: tb/tb_jram_sync.sv
// Bench for jram_sync: RD_LAT=1 and RD_LAT=2 instances driven in lockstep, reads scored from a reference model.
module tb_jram_sync;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jram_sync_if #(.DW(DW), .AW(AW)) bus1 ();
  jram_sync_if #(.DW(DW), .AW(AW)) bus2 ();

  jram_sync #(.DW(DW), .AW(AW), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  jram_sync #(.DW(DW), .AW(AW), .RD_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] mmem [DEPTH];
  logic [AW-1:0] mmar;
  int            mclr = 0;
  bit            mon_en = 1'b0;
  bit            use_exp = 1'b0;
  logic [DW-1:0] exp_val;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one clock of stimulus into both instances and advance the model.
  task automatic step(input logic r_n, input logic wsa, input logic [AW-1:0] bas,
                      input logic ws, input logic [DW-1:0] bis, input logic we);
    exp_t e;
    rst_n = r_n;
    bus1.wsa = wsa; bus2.wsa = wsa;
    bus1.bas = bas; bus2.bas = bas;
    bus1.ws  = ws;  bus2.ws  = ws;
    bus1.bis = bis; bus2.bis = bis;
    bus1.we  = we;  bus2.we  = we;
    if (!r_n) begin
      q1.delete();
      q2.delete();
      mmar = '0;
      mclr = DEPTH;
      foreach (mmem[i]) mmem[i] = '0;
    end else if (mclr > 0) begin
      mclr--;
    end else begin
      if (we) begin
        e.data = use_exp ? exp_val : mmem[mmar];
        e.due  = cyc + 1; q1.push_back(e);
        e.due  = cyc + 2; q2.push_back(e);
      end
      if (ws) mmem[mmar] = bis;
      if (wsa) mmar = bas;
`ifdef JRAM_AUTOINC_EN
      else if (ws || we) mmar = mmar + AW'(1);
`endif
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic read_exp(input logic [AW-1:0] a, input logic [DW-1:0] v);
    step(1'b1, 1'b1, a, 1'b0, '0, 1'b0);
    use_exp = 1'b1; exp_val = v;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    use_exp = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus1.busy !== 1'b1) break;
      n++;
      idle();
    end
  endtask

  // Scoreboard monitor: each cycle either a due read or an idle (zero) bus.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (q1.size() > 0 && q1[0].due == cyc) begin
          if (bus1.valid !== 1'b1 || bus1.bos !== q1[0].data) begin
            errors++;
            $display("FAIL rd_lat1 cyc=%0d valid=%b bos=%h want valid=1 bos=%h", cyc, bus1.valid, bus1.bos, q1[0].data);
          end
          void'(q1.pop_front());
        end else if (bus1.valid !== 1'b0 || bus1.bos !== '0) begin
          errors++;
          $display("FAIL idle_lat1 cyc=%0d valid=%b bos=%h want valid=0 bos=00", cyc, bus1.valid, bus1.bos);
        end
        checks++;
        if (q2.size() > 0 && q2[0].due == cyc) begin
          if (bus2.valid !== 1'b1 || bus2.bos !== q2[0].data) begin
            errors++;
            $display("FAIL rd_lat2 cyc=%0d valid=%b bos=%h want valid=1 bos=%h", cyc, bus2.valid, bus2.bos, q2[0].data);
          end
          void'(q2.pop_front());
        end else if (bus2.valid !== 1'b0 || bus2.bos !== '0) begin
          errors++;
          $display("FAIL idle_lat2 cyc=%0d valid=%b bos=%h want valid=0 bos=00", cyc, bus2.valid, bus2.bos);
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    mon_en = 1'b1;
    checks++;
    if (bus1.busy !== 1'b1 || bus2.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy got %b/%b want 1/1", bus1.busy, bus2.busy);
    end
    checks++;
    if (bus1.mar !== '0 || bus2.mar !== '0) begin
      errors++; $display("FAIL reset_mar got %h/%h want 00/00", bus1.mar, bus2.mar);
    end
    count_busy(n);
    checks++;
    if (n != 256 || bus2.busy !== 1'b0) begin
      errors++; $display("FAIL clear_len got %0d busy2=%b want 256 busy2=0", n, bus2.busy);
    end
    step(1'b1, 1'b1, 8'h10, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'hFF, 1'b0);
    read_exp(8'h10, 8'hFF);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    count_busy(n);
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL clear_len2 got %0d want 256", n);
    end
    read_exp(8'h10, 8'h00);
    read_exp(8'hFF, 8'h00);
  endtask

  task automatic test_basic();
    step(1'b1, 1'b1, 8'h3C, 1'b0, '0, 1'b0);
    checks++;
    if (bus1.mar !== 8'h3C || bus2.mar !== 8'h3C) begin
      errors++; $display("FAIL mar_load got %h/%h want 3c", bus1.mar, bus2.mar);
    end
    step(1'b1, 1'b0, '0, 1'b1, 8'hA5, 1'b0);
    read_exp(8'h3C, 8'hA5);
    idle(); idle(); idle();
  endtask

  task automatic test_hazards();
    step(1'b1, 1'b1, 8'h06, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'h66, 1'b0);
    step(1'b1, 1'b1, 8'h05, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'h06, 1'b1, 8'h11, 1'b0);
    checks++;
    if (bus1.mar !== 8'h06 || bus2.mar !== 8'h06) begin
      errors++; $display("FAIL wsa_ws_mar got %h/%h want 06", bus1.mar, bus2.mar);
    end
    read_exp(8'h05, 8'h11);
    read_exp(8'h06, 8'h66);
    step(1'b1, 1'b1, 8'h07, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'h22, 1'b0);
    step(1'b1, 1'b1, 8'h07, 1'b0, '0, 1'b0);
    use_exp = 1'b1; exp_val = 8'h22;
    step(1'b1, 1'b0, '0, 1'b1, 8'h33, 1'b1);
    use_exp = 1'b0;
    read_exp(8'h07, 8'h33);
  endtask

  task automatic test_busy_ignore();
    int n;
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 8'h55, 1'b1, 8'h77, 1'b1);
      checks++;
      if (bus1.mar !== '0 || bus2.mar !== '0) begin
        errors++; $display("FAIL busy_mar k=%0d got %h/%h want 00", k, bus1.mar, bus2.mar);
      end
    end
    count_busy(n);
    checks++;
    if (n != 252) begin
      errors++; $display("FAIL busy_remaining got %0d want 252", n);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
    use_exp = 1'b1; exp_val = '0;
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, AW'(i), 1'b0, '0, 1'b1);
    use_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, AW'(8'h80 + i), 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, DW'($urandom_range(1, 255)), 1'b0);
    end
    step(1'b1, 1'b1, 8'h80, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, AW'(8'h80 + i), 1'b0, '0, 1'b1);
    idle(); idle(); idle();
  endtask

  task automatic test_reset_mid_read();
    int n;
    step(1'b1, 1'b1, 8'h3C, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'hA5, 1'b0);
    step(1'b1, 1'b1, 8'h3C, 1'b0, '0, 1'b0);
    use_exp = 1'b1; exp_val = 8'hA5;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    use_exp = 1'b0;
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    checks++;
    if (bus2.valid !== 1'b0 || bus2.bos !== '0 || bus2.busy !== 1'b1 || bus2.mar !== '0) begin
      errors++; $display("FAIL mid_read_reset got valid=%b bos=%h busy=%b mar=%h want 0 00 1 00",
                         bus2.valid, bus2.bos, bus2.busy, bus2.mar);
    end
    count_busy(n);
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL mid_read_sweep got %0d want 256", n);
    end
  endtask

  task automatic test_autoinc();
    logic [AW-1:0] want_mar;
    step(1'b1, 1'b1, 8'hFE, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'h01, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'h02, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'h03, 1'b0);
`ifdef JRAM_AUTOINC_EN
    want_mar = 8'h01;
`else
    want_mar = 8'hFE;
`endif
    checks++;
    if (bus1.mar !== want_mar || bus2.mar !== want_mar) begin
      errors++; $display("FAIL autoinc_mar got %h/%h want %h", bus1.mar, bus2.mar, want_mar);
    end
`ifdef JRAM_AUTOINC_EN
    read_exp(8'hFE, 8'h01);
    read_exp(8'hFF, 8'h02);
    read_exp(8'h00, 8'h03);
`else
    read_exp(8'hFE, 8'h03);
    read_exp(8'hFF, 8'h00);
    read_exp(8'h00, 8'h00);
`endif
    idle(); idle(); idle();
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.wsa = 1'b0; bus1.bas = '0; bus1.ws = 1'b0; bus1.bis = '0; bus1.we = 1'b0;
    bus2.wsa = 1'b0; bus2.bas = '0; bus2.ws = 1'b0; bus2.bis = '0; bus2.we = 1'b0;
    @(negedge clk);
    #1;
    test_reset();
    test_basic();
    test_hazards();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_read();
    test_autoinc();
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++; $display("FAIL drain got %0d/%0d pending want 0/0", q1.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jram_sync.md
Name: jram_sync

Overview:
- Clocked, parametrised successor to the 256x8 bus RAM. It keeps the MAR-addressed model: address latched from the address bus, then set/enable strobes for write/read.
- Adds generic data/address width, a registered read path with selectable latency, a read-valid flag, and a post-reset hardware clear sweep with a busy flag.
- Sits on the CPU address/data buses next to the register file. The output drives zero when not presenting read data, so it can share the wired-OR data bus.

Parameters:
- DW, 8, data width in bits.
- AW, 8, address width; DEPTH = 2**AW words.
- RD_LAT, 1, read latency in clock edges; legal values 1 or 2. Any other value must stop elaboration.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- bas  in  AW  address bus.
- wsa  in  1  set-address strobe: MAR <= bas.
- bis  in  DW  write data bus.
- ws  in  1  set strobe: mem[MAR] <= bis.
- we  in  1  enable strobe: read mem[MAR].
- bos  out  DW  read data; 0 whenever valid=0.
- valid  out  1  bos carries read data this cycle.
- busy  out  1  clear sweep in progress; commands ignored.
- mar  out  AW  current MAR value, for debug and bus monitor.

Behaviour:
- Reset: rst_n sampled low at a rising edge gives MAR=0, bos=0, valid=0, busy=1, clear pointer=0, state=CLEAR. Memory array is not reset directly.
- FSM has two states, CLEAR and IDLE.
- CLEAR state:
  - Each cycle: mem[clr_ptr] <= 0, clr_ptr++.
  - On the edge that writes address DEPTH-1, go to IDLE; busy falls at that edge.
  - CLEAR lasts exactly DEPTH cycles after rst_n returns high.
  - wsa, ws and we are ignored; MAR holds 0; valid stays 0.
- IDLE, all strobes sampled on the rising edge:
  - wsa=1: MAR <= bas.
  - ws=1: mem[MAR_old] <= bis. MAR_old is the MAR value before this edge, so wsa+ws in the same cycle writes the old address.
  - we=1: read mem[MAR_old].
    - RD_LAT=1: data on bos with valid=1 in the cycle after the edge.
    - RD_LAT=2: one cycle later.
    - valid is high for exactly one cycle per sampled we.
  - Back-to-back we cycles give back-to-back valid cycles (fully pipelined, one read per clock).
  - ws and we at the same address in the same cycle: read returns the pre-write data (read-before-write).
  - No strobes: state unchanged; bos=0, valid=0 once the pipeline drains.
- Wrap-around: MAR arithmetic is modulo DEPTH; no out-of-range address exists.
- Reset mid-operation: in-flight reads are dropped, so no valid pulse after a reset edge. A pending write on the reset edge is not performed. CLEAR restarts from address 0.
- Reset during CLEAR restarts the sweep.
- All outputs are registered: bos, valid, busy and mar come from flops, with no combinational path from inputs.

Optional Feature:
- Macro: JRAM_AUTOINC_EN.
- With the macro defined, in IDLE:
  - A sampled ws or we without wsa also does MAR <= MAR+1 mod DEPTH.
  - ws+we together increment once.
  - wsa always has priority: MAR <= bas with no increment.
  - The access itself still uses MAR_old.
- Without the macro: MAR changes only on wsa or reset.

Test Plan:
- Reset clear (AW=8): write 0xFF to 0x10, pulse rst_n low 1 cycle, then hold it high.
  - Required: busy=1 for exactly 256 cycles.
  - After that, a read of 0x10 returns bos=0x00 with valid=1, and a read of 0xFF returns 0x00.
- Basic write/read, RD_LAT=1 and RD_LAT=2: wsa with bas=0x3C, then ws with bis=0xA5, then we.
  - Required: bos=0xA5 with valid=1 exactly 1 (resp. 2) cycles after the we edge; bos=0x00 otherwise.
- Same-cycle hazards:
  - MAR=0x05, wsa with bas=0x06 plus ws with bis=0x11 in one cycle: mem[0x05]=0x11, mem[0x06] unchanged.
  - mem[0x07]=0x22, then ws with bis=0x33 plus we at 0x07: read returns 0x22; the next read returns 0x33.
- Busy ignore: issue wsa, ws, we during CLEAR.
  - Required: valid never asserted, MAR stays 0, and all words read 0x00 after CLEAR.
- Reset mid-read (RD_LAT=2): we at 0x3C (holding 0xA5), rst_n low on the next edge.
  - Required: no valid pulse, bos=0, busy=1, sweep restarts.
- JRAM_AUTOINC_EN: wsa with bas=0xFE, then ws with bis 0x01, 0x02, 0x03 on consecutive cycles.
  - Required: mem[0xFE]=0x01, mem[0xFF]=0x02, mem[0x00]=0x03, and mar=0x01 afterwards.
  - Without the macro: mem[0xFE]=0x03 and mar=0xFE.
